// File: rtl/dii_echo_endpoint.sv
// Bank of DII stub endpoints that echo packets back with src/dest swapped.
// Optional per-channel statistics counters: define DII_ECHO_STATS_EN.
module dii_echo_endpoint #(
  parameter int unsigned PORTS   = 1,
  parameter logic [15:0] ID_BASE = 16'h0010,
  parameter int unsigned MAX_LEN = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [16*PORTS-1:0] in_flat_data,
  input  logic [PORTS-1:0]    in_flat_first,
  input  logic [PORTS-1:0]    in_flat_last,
  input  logic [PORTS-1:0]    in_flat_valid,
  output logic [PORTS-1:0]    in_flat_ready,
  output logic [16*PORTS-1:0] out_flat_data,
  output logic [PORTS-1:0]    out_flat_first,
  output logic [PORTS-1:0]    out_flat_last,
  output logic [PORTS-1:0]    out_flat_valid,
  input  logic [PORTS-1:0]    out_flat_ready
`ifdef DII_ECHO_STATS_EN
  ,
  output logic [16*PORTS-1:0] stat_flat_echoed,
  output logic [16*PORTS-1:0] stat_flat_dropped
`endif
);

  localparam int unsigned LW    = $clog2(MAX_LEN + 1);
  localparam int unsigned DEPTH = 2 ** LW;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    DROP,
    SEND
  } state_e;

  for (genvar g = 0; g < PORTS; g++) begin : g_ch
    localparam logic [15:0] MY_ID = 16'(ID_BASE + 16'(g));

    state_e        state_q;
    logic [15:0]   buf_q [DEPTH];
    logic [LW-1:0] len_q;
    logic [LW-1:0] idx_q;
    logic [15:0]   od_q;
    logic          of_q;
    logic          ol_q;
    logic          ov_q;

    logic [15:0]   in_d;
    logic          in_f;
    logic          in_l;
    logic          in_v;
    logic          rdy;
    logic          acc;
    logic          out_hs;
    logic [LW-1:0] nxt;
    logic          full;

    assign in_d   = in_flat_data[16*g +: 16];
    assign in_f   = in_flat_first[g];
    assign in_l   = in_flat_last[g];
    assign in_v   = in_flat_valid[g];
    assign rdy    = ~rst & (state_q != SEND);
    assign acc    = in_v & rdy;
    assign out_hs = ov_q & out_flat_ready[g];
    assign nxt    = idx_q + 1'b1;
    assign full   = (len_q == LW'(MAX_LEN));

    assign in_flat_ready[g]         = rdy;
    assign out_flat_data[16*g +: 16] = od_q;
    assign out_flat_first[g]        = of_q;
    assign out_flat_last[g]         = ol_q;
    assign out_flat_valid[g]        = ov_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= IDLE;
        len_q   <= '0;
        idx_q   <= '0;
        od_q    <= '0;
        of_q    <= 1'b0;
        ol_q    <= 1'b0;
        ov_q    <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (acc && in_f && !in_l) begin
              buf_q[0] <= in_d;
              len_q    <= LW'(1);
              state_q  <= RECV;
            end
          end
          RECV: begin
            if (acc) begin
              if (in_f) begin
                buf_q[0] <= in_d;
                len_q    <= LW'(1);
                state_q  <= in_l ? IDLE : RECV;
              end else if (full) begin
                state_q <= in_l ? IDLE : DROP;
              end else begin
                buf_q[len_q] <= in_d;
                len_q        <= len_q + 1'b1;
                if (in_l) begin
                  if (buf_q[0] == MY_ID) begin
                    state_q <= SEND;
                    idx_q   <= '0;
                    ov_q    <= 1'b1;
                    of_q    <= 1'b1;
                    ol_q    <= 1'b0;
                    // A 2-word packet's src is the word arriving right now
                    od_q    <= (len_q == LW'(1)) ? in_d : buf_q[1];
                  end else begin
                    state_q <= IDLE;
                  end
                end
              end
            end
          end
          DROP: begin
            if (acc && in_l) state_q <= IDLE;
          end
          SEND: begin
            if (out_hs) begin
              if (ol_q) begin
                ov_q    <= 1'b0;
                of_q    <= 1'b0;
                ol_q    <= 1'b0;
                state_q <= IDLE;
              end else begin
                idx_q <= nxt;
                of_q  <= 1'b0;
                ol_q  <= (nxt == len_q - 1'b1);
                od_q  <= (nxt == LW'(1)) ? MY_ID : buf_q[nxt];
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end

`ifdef DII_ECHO_STATS_EN
    logic [15:0] echo_cnt_q;
    logic [15:0] drop_cnt_q;
    logic        echo_ev;
    logic        drop_ev;
    logic        recv_drop;

    assign echo_ev   = (state_q == SEND) & out_hs & ol_q;
    assign recv_drop = (state_q == RECV) &
                       (in_f | full | (in_l & (buf_q[0] != MY_ID)));
    assign drop_ev   = acc &
                       (((state_q == IDLE) & in_f & in_l) | recv_drop);

    always_ff @(posedge clk) begin
      if (rst) begin
        echo_cnt_q <= '0;
        drop_cnt_q <= '0;
      end else begin
        if (echo_ev && echo_cnt_q != 16'hFFFF)
          echo_cnt_q <= echo_cnt_q + 16'd1;
        if (drop_ev && drop_cnt_q != 16'hFFFF)
          drop_cnt_q <= drop_cnt_q + 16'd1;
      end
    end

    assign stat_flat_echoed[16*g +: 16]  = echo_cnt_q;
    assign stat_flat_dropped[16*g +: 16] = drop_cnt_q;
`endif
  end

endmodule

// File: tb/tb_dii_echo_endpoint.sv
// Directed self-checking bench for dii_echo_endpoint (PORTS=2, MAX_LEN=8).
// Stat checks are active when DII_ECHO_STATS_EN is defined.
module tb_dii_echo_endpoint;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_flat_data;
  logic [1:0]  in_flat_first;
  logic [1:0]  in_flat_last;
  logic [1:0]  in_flat_valid;
  logic [1:0]  in_flat_ready;
  logic [31:0] out_flat_data;
  logic [1:0]  out_flat_first;
  logic [1:0]  out_flat_last;
  logic [1:0]  out_flat_valid;
  logic [1:0]  out_flat_ready;
`ifdef DII_ECHO_STATS_EN
  logic [31:0] stat_flat_echoed;
  logic [31:0] stat_flat_dropped;
`endif

  int errors = 0;
  int checks = 0;
  logic [15:0] pkt[$];
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  dii_echo_endpoint #(
    .PORTS(2),
    .ID_BASE(16'h0010),
    .MAX_LEN(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_flat_data(in_flat_data),
    .in_flat_first(in_flat_first),
    .in_flat_last(in_flat_last),
    .in_flat_valid(in_flat_valid),
    .in_flat_ready(in_flat_ready),
    .out_flat_data(out_flat_data),
    .out_flat_first(out_flat_first),
    .out_flat_last(out_flat_last),
    .out_flat_valid(out_flat_valid),
    .out_flat_ready(out_flat_ready)
`ifdef DII_ECHO_STATS_EN
    ,
    .stat_flat_echoed(stat_flat_echoed),
    .stat_flat_dropped(stat_flat_dropped)
`endif
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(int ch, logic [15:0] d, logic f, logic l);
    chk($sformatf("in_ready_ch%0d", ch), 32'(in_flat_ready[ch]), 1);
    in_flat_data[16*ch +: 16] = d;
    in_flat_first[ch] = f;
    in_flat_last[ch]  = l;
    in_flat_valid[ch] = 1'b1;
    tick();
    in_flat_valid[ch] = 1'b0;
    in_flat_first[ch] = 1'b0;
    in_flat_last[ch]  = 1'b0;
  endtask

  task automatic send_pkt(int ch);
    for (int i = 0; i < pkt.size(); i++)
      drive(ch, pkt[i], i == 0, i == pkt.size() - 1);
  endtask

  task automatic chk_word(int ch, int k);
    string s;
    s = $sformatf("ch%0d_w%0d", ch, k);
    chk({s, "_valid"}, 32'(out_flat_valid[ch]), 1);
    chk({s, "_data"}, 32'(out_flat_data[16*ch +: 16]), 32'(exp_q[k]));
    chk({s, "_first"}, 32'(out_flat_first[ch]), 32'(k == 0));
    chk({s, "_last"}, 32'(out_flat_last[ch]), 32'(k == exp_q.size() - 1));
    chk({s, "_in_ready"}, 32'(in_flat_ready[ch]), 0);
    chk({s, "_other_quiet"}, 32'(out_flat_valid[1-ch]), 0);
  endtask

  task automatic expect_echo(int ch, bit toggle);
    for (int k = 0; k < exp_q.size(); k++) begin
      if (toggle) begin
        out_flat_ready[ch] = 1'b0;
        chk_word(ch, k);
        tick();
        chk_word(ch, k);
        out_flat_ready[ch] = 1'b1;
      end
      chk_word(ch, k);
      tick();
    end
    chk($sformatf("ch%0d_done_valid", ch), 32'(out_flat_valid[ch]), 0);
    chk($sformatf("ch%0d_done_in_ready", ch), 32'(in_flat_ready[ch]), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst            = 1'b1;
    in_flat_data   = '0;
    in_flat_first  = '0;
    in_flat_last   = '0;
    in_flat_valid  = '0;
    out_flat_ready = 2'b11;
    tick();
    tick();
    chk("rst_in_ready", 32'(in_flat_ready), 0);
    chk("rst_out_valid", 32'(out_flat_valid), 0);
    chk("rst_out_data", out_flat_data, 0);
    chk("rst_out_first", 32'(out_flat_first), 0);
    chk("rst_out_last", 32'(out_flat_last), 0);
    rst = 1'b0;
    tick();
    chk("post_rst_in_ready", 32'(in_flat_ready), 32'h3);
`ifdef DII_ECHO_STATS_EN
    chk("rst_stat_echoed", stat_flat_echoed, 0);
    chk("rst_stat_dropped", stat_flat_dropped, 0);
`endif

    // basic echo on channel 1
    pkt   = '{16'h0011, 16'h0001, 16'hA5A5, 16'h5A5A};
    exp_q = '{16'h0001, 16'h0011, 16'hA5A5, 16'h5A5A};
    send_pkt(1);
    expect_echo(1, 1'b0);

    // same packet under output backpressure
    send_pkt(1);
    expect_echo(1, 1'b1);

    // misaddressed packet on channel 0
    pkt = '{16'h0022, 16'h0001, 16'h1234, 16'h5678};
    send_pkt(0);
    chk("misaddr_valid_a", 32'(out_flat_valid[0]), 0);
    tick();
    chk("misaddr_valid_b", 32'(out_flat_valid[0]), 0);
    chk("misaddr_in_ready", 32'(in_flat_ready[0]), 1);
`ifdef DII_ECHO_STATS_EN
    chk("misaddr_dropped0", 32'(stat_flat_dropped[15:0]), 1);
    chk("misaddr_echoed0", 32'(stat_flat_echoed[15:0]), 0);
`endif

    // minimal two-word packet
    pkt   = '{16'h0010, 16'h0042};
    exp_q = '{16'h0042, 16'h0010};
    send_pkt(0);
    expect_echo(0, 1'b0);

    // oversize packet then a valid one
    pkt = '{16'h0010, 16'h0001, 16'h0002, 16'h0003, 16'h0004,
            16'h0005, 16'h0006, 16'h0007, 16'h0008, 16'h0009};
    send_pkt(0);
    chk("oversize_valid_a", 32'(out_flat_valid[0]), 0);
    tick();
    chk("oversize_valid_b", 32'(out_flat_valid[0]), 0);
    pkt   = '{16'h0010, 16'h0007, 16'hBEEF};
    exp_q = '{16'h0007, 16'h0010, 16'hBEEF};
    send_pkt(0);
    expect_echo(0, 1'b0);
`ifdef DII_ECHO_STATS_EN
    chk("oversize_dropped0", 32'(stat_flat_dropped[15:0]), 2);
    chk("oversize_echoed0", 32'(stat_flat_echoed[15:0]), 2);
`endif

    // packet aborted by a new first word
    drive(1, 16'h0011, 1'b1, 1'b0);
    drive(1, 16'h0002, 1'b0, 1'b0);
    drive(1, 16'h1111, 1'b0, 1'b0);
    drive(1, 16'h0011, 1'b1, 1'b0);
    drive(1, 16'h0003, 1'b0, 1'b0);
    drive(1, 16'h2222, 1'b0, 1'b1);
    exp_q = '{16'h0003, 16'h0011, 16'h2222};
    expect_echo(1, 1'b0);
`ifdef DII_ECHO_STATS_EN
    chk("abort_dropped1", 32'(stat_flat_dropped[31:16]), 1);
    chk("abort_echoed1", 32'(stat_flat_echoed[31:16]), 3);
`endif

    // reset in the middle of an echo
    pkt   = '{16'h0011, 16'h0001, 16'hA5A5, 16'h5A5A};
    exp_q = '{16'h0001, 16'h0011, 16'hA5A5, 16'h5A5A};
    send_pkt(1);
    chk_word(1, 0);
    tick();
    chk_word(1, 1);
    tick();
    chk("mid_word2_data", 32'(out_flat_data[31:16]), 32'hA5A5);
    rst = 1'b1;
    tick();
    chk("mid_rst_valid", 32'(out_flat_valid), 0);
    chk("mid_rst_data", out_flat_data, 0);
    chk("mid_rst_in_ready", 32'(in_flat_ready), 0);
    rst = 1'b0;
    tick();
    chk("after_rst_in_ready", 32'(in_flat_ready), 32'h3);
    chk("after_rst_valid", 32'(out_flat_valid), 0);
`ifdef DII_ECHO_STATS_EN
    chk("after_rst_echoed", stat_flat_echoed, 0);
    chk("after_rst_dropped", stat_flat_dropped, 0);
`endif
    send_pkt(1);
    expect_echo(1, 1'b0);
`ifdef DII_ECHO_STATS_EN
    chk("final_echoed1", 32'(stat_flat_echoed[31:16]), 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
